// File: rtl/bcd_serial_checker_pkg.sv
// Shared types and constants for the BCD serial checker: FSM states and nibble geometry.
package bcd_serial_checker_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int BIT_CNT_W = $clog2(NIBBLE_W);

    // Bit index positions within the serial stream (MSB first)
    localparam logic [BIT_CNT_W-1:0] FIRST_BIT = BIT_CNT_W'(0);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(NIBBLE_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_checker_judge.sv
// Serial BCD judgement: watches the MSB-first bit stream and flags codes 10..15.
module bcd_bit_judge
    import bcd_serial_checker_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 serial_bit,
    input  logic [BIT_CNT_W-1:0] count,
    output logic                 is_bcd
);

    logic hi;
    logic bad;

    // A nibble is non-BCD only when bit 3 is set together with bit 2 or bit 1;
    // the final bit can never change the verdict, so it is ignored.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            hi  <= 1'b0;
            bad <= 1'b0;
        end else if (serial_bit) begin
            if (count == FIRST_BIT) begin
                hi <= 1'b1;
            end else if (count != LAST_BIT && hi) begin
                bad <= 1'b1;
            end
        end
    end

    assign is_bcd = ~bad;

endmodule

// File: rtl/bcd_serial_checker.sv
// Accepts a nibble, shifts it out MSB first on linea, then holds a BCD verdict until consumed.
module bcd_serial_checker
    import bcd_serial_checker_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] in_nibble,
    output logic                linea,
    output logic                linea_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_is_bcd,
    output logic [CNT_W-1:0]    ok_count,
    output logic [CNT_W-1:0]    bad_count
);

    state_t                state;
    logic [NIBBLE_W-1:0]   shift_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  judge_start;
    logic                  judge_is_bcd;
    logic                  verdict_taken;

    assign in_ready      = (state == IDLE);
    assign linea_valid   = (state == SHIFT);
    assign linea         = linea_valid & shift_reg[NIBBLE_W-1];
    assign out_valid     = (state == RESULT);
    assign out_is_bcd    = out_valid & judge_is_bcd;
    assign judge_start   = in_ready & in_valid;
    assign verdict_taken = out_valid & out_ready;

    // Unknown state encodings fall through to default and recover to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_nibble;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[NIBBLE_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state <= RESULT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The judge only ever sees linea, so the verdict is derived from the serial stream itself.
    bcd_bit_judge u_judge (
        .clock      (clock),
        .reset      (reset),
        .start      (judge_start),
        .serial_bit (linea),
        .count      (bit_cnt),
        .is_bcd     (judge_is_bcd)
    );

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            ok_count  <= '0;
            bad_count <= '0;
        end else if (verdict_taken) begin
            if (judge_is_bcd) begin
                if (ok_count != {CNT_W{1'b1}}) begin
                    ok_count <= ok_count + CNT_W'(1);
                end
            end else begin
                if (bad_count != {CNT_W{1'b1}}) begin
                    bad_count <= bad_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_checker.sv
// Self-checking bench: directed scenarios plus random nibbles against a behavioural model.
module tb_bcd_serial_checker;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_nibble;
    logic       out_ready;

    logic       in_ready, linea, linea_valid, out_valid, out_is_bcd;
    logic [7:0] ok_count, bad_count;
    logic       s_in_ready, s_linea, s_linea_valid, s_out_valid, s_out_is_bcd;
    logic [1:0] s_ok_count, s_bad_count;

    int checks   = 0;
    int failures = 0;
    int ok_m     = 0;
    int bad_m    = 0;

    always #5 clock = ~clock;

    bcd_serial_checker #(.CNT_W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_nibble(in_nibble), .linea(linea), .linea_valid(linea_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_bcd(out_is_bcd),
        .ok_count(ok_count), .bad_count(bad_count)
    );

    bcd_serial_checker #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_nibble(in_nibble), .linea(s_linea), .linea_valid(s_linea_valid),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_is_bcd(s_out_is_bcd),
        .ok_count(s_ok_count), .bad_count(s_bad_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, ".ok"},      32'(ok_count),    32'(sat(ok_m, 255)));
        check({tag, ".bad"},     32'(bad_count),   32'(sat(bad_m, 255)));
        check({tag, ".sat_ok"},  32'(s_ok_count),  32'(sat(ok_m, 3)));
        check({tag, ".sat_bad"}, 32'(s_bad_count), 32'(sat(bad_m, 3)));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},    32'(in_ready),    32'd1);
        check({tag, ".linea"},       32'(linea),       32'd0);
        check({tag, ".linea_valid"}, 32'(linea_valid), 32'd0);
        check({tag, ".out_valid"},   32'(out_valid),   32'd0);
        check({tag, ".out_is_bcd"},  32'(out_is_bcd),  32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        ok_m  = 0;
        bad_m = 0;
        check_idle("reset");
        check_counts("reset");
        reset = 1'b0;
    endtask

    // Offer one nibble from an idle negedge, follow it through shift and verdict,
    // hold the verdict for hold_cycles before consuming it. Junk on in_valid
    // while busy must be ignored.
    task automatic apply_stimulus(input logic [3:0] nib, input int hold_cycles, input string tag);
        logic exp_bcd;
        exp_bcd = (nib <= 4'd9);
        check({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_nibble = nib;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            in_valid  = 1'($urandom_range(0, 1));
            in_nibble = 4'($urandom);
            check({tag, ".linea"},       32'(linea),       32'(nib[3 - i]));
            check({tag, ".linea_valid"}, 32'(linea_valid), 32'd1);
            check({tag, ".busy_ready"},  32'(in_ready),    32'd0);
        end
        for (int h = 0; h <= hold_cycles; h++) begin
            @(negedge clock);
            check({tag, ".out_valid"},   32'(out_valid),     32'd1);
            check({tag, ".out_is_bcd"},  32'(out_is_bcd),    32'(exp_bcd));
            check({tag, ".sat_is_bcd"},  32'(s_out_is_bcd),  32'(exp_bcd));
            check({tag, ".result_rdy"},  32'(in_ready),      32'd0);
            check({tag, ".result_lv"},   32'(linea_valid),   32'd0);
            check_counts({tag, ".held"});
            if (h == hold_cycles) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end else begin
                in_valid  = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clock);
        out_ready = 1'b0;
        if (exp_bcd) ok_m++;
        else         bad_m++;
        check_idle({tag, ".after"});
        check_counts({tag, ".after"});
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_nibble = 4'h0;
        out_ready = 1'b0;
        $display("[TB] start");
        apply_reset();

        apply_stimulus(4'h9, 0, "nib9");
        apply_stimulus(4'hA, 0, "nibA");
        apply_stimulus(4'hF, 0, "nibF");
        check("two_bad", 32'(bad_count), 32'd2);
        apply_stimulus(4'h7, 10, "hold7");
        check("hold_once", 32'(ok_count), 32'd2);

        apply_reset();
        for (int n = 0; n < 16; n++) begin
            apply_stimulus(4'(n), 0, "exh");
        end
        check("exh_ok",  32'(ok_count),  32'd10);
        check("exh_bad", 32'(bad_count), 32'd6);

        // Reset lands on the second shift cycle of 0xC; the verdict is dropped.
        apply_reset();
        in_valid  = 1'b1;
        in_nibble = 4'hC;
        @(negedge clock);
        in_valid = 1'b0;
        check("abort.linea0", 32'(linea), 32'd1);
        @(negedge clock);
        check("abort.linea1", 32'(linea_valid), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_idle("abort");
        check_counts("abort");
        @(negedge clock);
        check_idle("abort.settle");
        apply_stimulus(4'h3, 0, "post_abort3");
        check("post_abort.ok", 32'(ok_count), 32'd1);

        apply_reset();
        for (int n = 0; n < 5; n++) begin
            apply_stimulus(4'h0, 0, "sat0");
            check("sat_seq", 32'(s_ok_count), 32'(sat(n + 1, 3)));
        end

        for (int n = 0; n < 24; n++) begin
            apply_stimulus(4'($urandom), $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_checker.md
BCD_SERIAL_CHECKER -- requirements
Module: bcd_serial_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the saturating statistics counters.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  nibble offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a nibble this cycle.
REQ-006 SHALL have port in_nibble  input  4  candidate BCD digit, bit 3 = MSB.
REQ-007 SHALL have port linea  output  1  current serial bit (MSB first) during SHIFT, 0 otherwise.
REQ-008 SHALL have port linea_valid  output  1  high exactly in cycles where linea carries a data bit.
REQ-009 SHALL have port out_valid  output  1  verdict available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts verdict.
REQ-011 SHALL have port out_is_bcd  output  1  1 when the serialized nibble was 0..9.
REQ-012 SHALL have port ok_count  output  CNT_W  number of nibbles judged BCD, saturating.
REQ-013 SHALL have port bad_count  output  CNT_W  number of nibbles judged non-BCD, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, RESULT; in_ready = 1 only in IDLE.
REQ-015 In IDLE, in_valid=1 SHALL capture in_nibble into a shift register, clear bit counter to 0, clear flags hi and bad, and go to SHIFT next cycle.
REQ-016 In SHIFT, linea SHALL equal shift register bit 3 and linea_valid = 1; register shifts left by one each cycle; bit counter increments 0->3.
REQ-017 Verdict SHALL be computed serially from linea only: count 0 with bit=1 sets hi; counts 1 or 2 with bit=1 while hi sets bad; count 3 bit ignored.
REQ-018 At count 3 the FSM SHALL go to RESULT; SHIFT therefore lasts exactly 4 cycles.
REQ-019 In RESULT, out_valid = 1 and out_is_bcd = ~bad; both SHALL hold stable until out_ready = 1.
REQ-020 RESULT with out_ready = 1 SHALL return to IDLE next cycle and increment ok_count (is_bcd) or bad_count (not) by one, saturating at 2^CNT_W-1.
REQ-021 Latency: nibble accepted cycle T -> linea bits T+1..T+4 -> out_valid first at T+5; peak throughput one nibble per 6 cycles.
REQ-022 in_valid while not in IDLE SHALL be ignored (no capture, in_ready = 0).
REQ-023 Counters SHALL not wrap; at saturation further verdicts of that kind leave the count unchanged.
REQ-024 Any FSM encoding outside the three states SHALL return to IDLE next cycle.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, shift register 0, bit counter 0, hi=0, bad=0, ok_count=0, bad_count=0, regardless of in-flight nibble or pending verdict.
REQ-026 Output values during/after reset: in_ready=1, linea=0, linea_valid=0, out_valid=0, out_is_bcd=0, counters 0.
REQ-027 A pending verdict aborted by reset SHALL not be counted.

Structure
REQ-028 Shared package SHALL hold the state enum (IDLE, SHIFT, RESULT) and the nibble-width constant 4.
REQ-029 One sub-module bcd_bit_judge SHALL hold the hi/bad serial judgement (inputs bit, count, start; outputs is_bcd); everything else inline.

Verification
REQ-030 Nibble 0x9, out_ready=1 -> linea 1,0,0,1 over 4 cycles, out_valid at T+5 with out_is_bcd=1, ok_count=1.
REQ-031 Nibble 0xA then 0xF back-to-back -> both out_is_bcd=0, bad_count=2, second in_ready only after first verdict consumed.
REQ-032 Nibble 0x7 with out_ready=0 for 10 cycles -> out_valid, out_is_bcd=1 held stable, in_ready=0 throughout, counted once on release.
REQ-033 CNT_W=2, five 0x0 nibbles -> ok_count sequence 1,2,3,3,3.
REQ-034 reset asserted at second SHIFT cycle of 0xC -> next cycle IDLE, linea_valid=0, no counter change, next nibble 0x3 judged BCD normally.
REQ-035 Exhaustive 0x0..0xF -> out_is_bcd=1 exactly for 0..9, ok_count=10, bad_count=6.
